// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg
//   Shared definitions for the pipeline stage register bank.
//   - PIPE_REG_DEF_BITS / PIPE_REG_DEF_DEPTH: default payload width and
//     stage count used by the core's stage instantiations.
//   - occ_w(depth): width of an occupancy counter able to hold 0..depth.
package pipe_reg_pkg;

  localparam int PIPE_REG_DEF_BITS  = 32;
  localparam int PIPE_REG_DEF_DEPTH = 3;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage
//   One register stage of the pipeline bank: a payload register and its
//   valid bit.
//   Ports:
//     clk          rising-edge clock
//     reset        synchronous, active-high; loads ResetValue, clears valid
//     load         advance qualifier (ClockEnable & Tick at the top)
//     flush        with load: clear valid, keep payload
//     hold         with load and no flush: keep contents instead of loading
//     d, d_valid   item from the previous stage (or the bank input)
//     q, q_valid   registered stage contents
//     q_valid_next valid bit this stage will hold after the coming edge,
//                  excluding reset; used by the top for occupancy
module pipe_reg_stage #(
  parameter int                  NrOfBits   = 32,
  parameter logic [NrOfBits-1:0] ResetValue = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                flush,
  input  logic                hold,
  input  logic [NrOfBits-1:0] d,
  input  logic                d_valid,
  output logic [NrOfBits-1:0] q,
  output logic                q_valid,
  output logic                q_valid_next
);

  logic take;

  // Flush wins over both hold and load; the payload is deliberately left
  // alone on flush so Q does not change when the bank is emptied.
  assign take = load & ~flush & ~hold;

  always_comb begin
    q_valid_next = q_valid;
    if (load & flush) begin
      q_valid_next = 1'b0;
    end else if (take) begin
      q_valid_next = d_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= ResetValue;
      q_valid <= 1'b0;
    end else begin
      q_valid <= q_valid_next;
      if (take) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Parametrised pipeline stage register bank. Carries a NrOfBits payload
//   through Depth register stages with per-stage valid bits, tick-qualified
//   advance, stall and flush, and a registered occupancy count.
//
//   Handshake: an item on D/InValid is captured into stage 0 on a rising
//   edge where ClockEnable & Tick is high and InReady is high. InReady is
//   combinational (~hold[0]); an item offered while it is low is not taken
//   and must be re-presented. OutValid/Q form the output side; Stall tells
//   the bank the consumer cannot take the output stage this advance.
//
//   Ports:
//     Clock, Reset         clock and synchronous active-high reset
//     ClockEnable, Tick    advance when both are high
//     D, InValid           input item
//     InReady              stage 0 will accept on an advance edge
//     Stall                consumer cannot accept the output stage
//     Flush                with advance: drop every in-flight item
//     Q, OutValid          output stage payload (not gated) and valid
//     Occupancy            registered count of valid stages
//
//   Build option PIPE_REG_BUBBLE_COLLAPSE_EN: when defined, a stall only
//   holds the contiguous run of valid stages ending at the output stage, so
//   items still move forward into empty stages. When undefined, Stall
//   freezes the whole bank.
module pipe_stage_reg
  import pipe_reg_pkg::*;
#(
  parameter int                  NrOfBits   = PIPE_REG_DEF_BITS,
  parameter int                  Depth      = PIPE_REG_DEF_DEPTH,
  parameter logic [NrOfBits-1:0] ResetValue = '0
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      ClockEnable,
  input  logic                      Tick,
  input  logic [NrOfBits-1:0]       D,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic                      Stall,
  input  logic                      Flush,
  output logic [NrOfBits-1:0]       Q,
  output logic                      OutValid,
  output logic [occ_w(Depth)-1:0]   Occupancy
);

  localparam int OccW = occ_w(Depth);

  logic                adv;
  logic [NrOfBits-1:0] data [Depth];
  logic [Depth-1:0]    valid;
  logic [Depth-1:0]    valid_n;
  logic [Depth-1:0]    hold;
  logic [OccW-1:0]     occ_next;

  assign adv = ClockEnable & Tick;

  // Hold chain runs from the output stage back to the input stage.
  always_comb begin
    hold = '0;
`ifdef PIPE_REG_BUBBLE_COLLAPSE_EN
    hold[Depth-1] = Stall & valid[Depth-1];
    for (int k = Depth - 2; k >= 0; k--) begin
      hold[k] = hold[k+1] & valid[k];
    end
`else
    hold[Depth-1] = Stall;
    for (int k = Depth - 2; k >= 0; k--) begin
      hold[k] = hold[k+1];
    end
`endif
  end

  for (genvar k = 0; k < Depth; k++) begin : g_stage
    logic [NrOfBits-1:0] src_data;
    logic                src_valid;

    if (k == 0) begin : g_src_in
      assign src_data  = D;
      assign src_valid = InValid;
    end else begin : g_src_prev
      assign src_data  = data[k-1];
      assign src_valid = valid[k-1];
    end

    pipe_reg_stage #(
      .NrOfBits  (NrOfBits),
      .ResetValue(ResetValue)
    ) u_stage (
      .clk         (Clock),
      .reset       (Reset),
      .load        (adv),
      .flush       (Flush),
      .hold        (hold[k]),
      .d           (src_data),
      .d_valid     (src_valid),
      .q           (data[k]),
      .q_valid     (valid[k]),
      .q_valid_next(valid_n[k])
    );
  end

  // Occupancy is registered from the post-update valid vector so it lines
  // up with the stage contents it describes.
  always_comb begin
    occ_next = '0;
    for (int k = 0; k < Depth; k++) begin
      occ_next = occ_next + OccW'(valid_n[k]);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Occupancy <= '0;
    end else begin
      Occupancy <= occ_next;
    end
  end

  assign Q        = data[Depth-1];
  assign OutValid = valid[Depth-1];
  assign InReady  = ~hold[0];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Self-checking bench for pipe_stage_reg with NrOfBits=8, Depth=3,
//   ResetValue=8'hA5. A behavioural model of the bank (arrays of items)
//   tracks expected contents; directed scenarios are followed by a
//   randomized phase.
module tb_pipe_stage_reg;

  localparam int W  = 8;
  localparam int DP = 3;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ce = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] d = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] q;
  logic         out_valid;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  // Reference model: item payloads and valid flags, index 0 = input stage.
  logic [W-1:0] m_data  [DP];
  logic         m_valid [DP];

  pipe_stage_reg #(
    .NrOfBits  (W),
    .Depth     (DP),
    .ResetValue(RV)
  ) dut (
    .Clock      (clk),
    .Reset      (rst),
    .ClockEnable(ce),
    .Tick       (tick),
    .D          (d),
    .InValid    (in_valid),
    .InReady    (in_ready),
    .Stall      (stall),
    .Flush      (flush),
    .Q          (q),
    .OutValid   (out_valid),
    .Occupancy  (occupancy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < DP; k++) n += m_valid[k] ? 1 : 0;
    return n;
  endfunction

  // A stalled bank refuses input unless some stage is empty (bubble mode).
  function automatic logic m_in_ready(input logic s);
`ifdef PIPE_REG_BUBBLE_COLLAPSE_EN
    return !(s && (m_count() == DP));
`else
    return !s;
`endif
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < DP; k++) begin
      m_data[k]  = RV;
      m_valid[k] = 1'b0;
    end
  endfunction

  // One rising edge of the reference bank.
  function automatic void m_edge(input logic r, input logic a, input logic f,
                                 input logic s, input logic [W-1:0] di,
                                 input logic vi);
    int top;
    if (r) begin
      m_reset();
    end else if (a && f) begin
      for (int k = 0; k < DP; k++) m_valid[k] = 1'b0;
    end else if (a) begin
      // Stages 0..top move forward by one; everything above stays put.
      top = s ? -1 : DP - 1;
`ifdef PIPE_REG_BUBBLE_COLLAPSE_EN
      if (s) for (int k = 0; k < DP; k++) if (!m_valid[k]) top = k;
`endif
      for (int k = top; k >= 1; k--) begin
        m_data[k]  = m_data[k-1];
        m_valid[k] = m_valid[k-1];
      end
      if (top >= 0) begin
        m_data[0]  = di;
        m_valid[0] = vi;
      end
    end
  endfunction

  // Driver: apply inputs for one cycle, check InReady before the edge and
  // registered outputs after it.
  task automatic step(input logic c, input logic t, input logic [W-1:0] di,
                      input logic vi, input logic s, input logic f,
                      input logic r);
    @(negedge clk);
    ce = c; tick = t; d = di; in_valid = vi; stall = s; flush = f; rst = r;
    #1;
    if (!r) chk("in_ready", in_ready, m_in_ready(s));
    @(posedge clk);
    m_edge(r, c & t, f, s, di, vi);
    #1;
    chk("q", q, m_data[DP-1]);
    chk("out_valid", out_valid, m_valid[DP-1]);
    chk("occupancy", occupancy, m_count());
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    m_reset();

    // Reset state
    do_reset();
    chk("rst_q", q, 32'hA5);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    @(negedge clk); rst = 1'b0; stall = 1'b0; #1;
    chk("rst_in_ready", in_ready, 1);

    // Stream with advance every cycle
    step(1, 1, 8'h01, 1, 0, 0, 0);
    chk("s1_occ", occupancy, 1);
    chk("s1_ov", out_valid, 0);
    step(1, 1, 8'h02, 1, 0, 0, 0);
    chk("s2_occ", occupancy, 2);
    chk("s2_q", q, 32'hA5);
    step(1, 1, 8'h03, 1, 0, 0, 0);
    chk("s3_q", q, 32'h01);
    chk("s3_ov", out_valid, 1);
    chk("s3_occ", occupancy, 3);
    step(1, 1, 8'h00, 0, 0, 0, 0);
    chk("s4_q", q, 32'h02);
    step(1, 1, 8'h00, 0, 0, 0, 0);
    chk("s5_q", q, 32'h03);
    step(1, 1, 8'h00, 0, 0, 0, 0);
    chk("s6_ov", out_valid, 0);

    // Tick only every 4th cycle
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1, (i % 4) == 3, 8'(i / 4 + 1), 1, 0, 0, 0);
    end
    chk("tick_q", q, 32'h01);
    chk("tick_ov", out_valid, 1);

    // Full bank stalled for 5 advance edges, 8'h09 offered
    for (int i = 0; i < 5; i++) step(1, 1, 8'h09, 1, 1, 0, 0);
    chk("stall_q", q, 32'h01);
    chk("stall_occ", occupancy, 3);
    @(negedge clk); #1;
    chk("stall_in_ready", in_ready, 0);

    // Flush overrides stall and drops the offered item
    step(1, 1, 8'h0A, 1, 1, 1, 0);
    chk("flush_ov", out_valid, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_q", q, 32'h01);
    @(negedge clk); stall = 1'b0; flush = 1'b0; ce = 1'b0; #1;
    chk("flush_in_ready", in_ready, 1);

    // Bubble at stage 1: items at stages 0 and 2, then stall
    step(1, 1, 8'h11, 1, 0, 0, 0);
    step(1, 1, 8'h00, 0, 0, 0, 0);
    step(1, 1, 8'h22, 1, 0, 0, 0);
    chk("bub_occ", occupancy, 2);
    step(1, 1, 8'h33, 1, 1, 0, 0);
`ifdef PIPE_REG_BUBBLE_COLLAPSE_EN
    chk("bub_occ_stalled", occupancy, 3);
`else
    chk("bub_occ_stalled", occupancy, 2);
`endif
    chk("bub_q", q, 32'h11);

    // Reset with ClockEnable low, stall high, two items in flight
    do_reset();
    step(1, 1, 8'h44, 1, 0, 0, 0);
    step(1, 1, 8'h55, 1, 0, 0, 0);
    step(0, 1, 8'h00, 0, 1, 0, 1);
    chk("rst2_q", q, 32'hA5);
    chk("rst2_occ", occupancy, 0);
    chk("rst2_ov", out_valid, 0);
    step(1, 1, 8'h66, 1, 0, 0, 0);
    step(1, 1, 8'h77, 1, 0, 0, 0);
    step(1, 1, 8'h00, 1, 1, 0, 1);
    chk("rst3_occ", occupancy, 0);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 3) != 0,
           8'($urandom_range(0, 255)),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
